// File: rtl/regfile_param_if.sv
// Request/response bundle for the parameterised register file.
// The master drives addresses, data and strobes; the slave returns read data and status.
interface regfile_param_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic            re;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            we;
  logic            clear;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            rvalid;
  logic            busy;

  modport master (
    output ra1, ra2, re, wa, wd, we, clear,
    input  rd1, rd2, rvalid, busy
  );

  modport slave (
    input  ra1, ra2, re, wa, wd, we, clear,
    output rd1, rd2, rvalid, busy
  );
endinterface

// File: rtl/regfile_param.sv
// Two-read/one-write register file with registered, write-first reads and a
// zeroing sweep that runs after reset and on request.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            resetn,
  regfile_param_if.slave  bus
);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic            rvalid_q, rvalid_d;
  logic            busy;
  logic            wr_ok;
  logic            wr_acc;
  logic            rd_acc;

  // Register 0 reads as zero even when a same-edge write targets it.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   ra,
    input logic [XLEN-1:0] stored,
    input logic            byp,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    if (ZERO_REG != 0 && ra == '0) return '0;
    if (byp && ra == wa)           return wd;
    return stored;
  endfunction

  assign busy   = (state_q == SWEEP);
  assign wr_ok  = bus.we && !(ZERO_REG != 0 && bus.wa == '0);
  assign wr_acc = !busy && wr_ok;
  assign rd_acc = !busy && bus.re;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      IDLE: begin
        if (bus.clear) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    rvalid_d = rd_acc;
    if (rd_acc) begin
      rd1_d = read_port(bus.ra1, mem_q[bus.ra1], wr_acc, bus.wa, bus.wd);
      rd2_d = read_port(bus.ra2, mem_q[bus.ra2], wr_acc, bus.wa, bus.wd);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= SWEEP;
      idx_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Array has no reset; the sweep that follows every reset zeroes it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[idx_q] <= '0;
    end else if (wr_acc) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  assign bus.rd1    = rd1_q;
  assign bus.rd2    = rd2_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param against an array-based reference model.
module tb_regfile_param;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int AW       = 5;
  localparam int ZERO_REG = 1;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  regfile_param_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_param #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [XLEN-1:0] m_mem [NREGS];
  logic [XLEN-1:0] m_rd1, m_rd2;
  logic            m_rvalid;
  int              m_busy;

  task automatic model_edge();
    logic wr;
    if (!resetn) return;
    if (m_busy > 0) begin
      m_busy   = m_busy - 1;
      m_rvalid = 1'b0;
      return;
    end
    wr = bus.we && !(ZERO_REG != 0 && bus.wa == 0);
    if (wr) m_mem[bus.wa] = bus.wd;
    if (bus.re) begin
      m_rd1 = (ZERO_REG != 0 && bus.ra1 == 0) ? '0 : m_mem[bus.ra1];
      m_rd2 = (ZERO_REG != 0 && bus.ra2 == 0) ? '0 : m_mem[bus.ra2];
    end
    m_rvalid = bus.re;
    if (bus.clear) begin
      m_busy = NREGS;
      for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ra1 = '0; bus.ra2 = '0; bus.re = 1'b0;
    bus.wa  = '0; bus.wd  = '0; bus.we = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic assert_reset();
    resetn   = 1'b0;
    m_rd1    = '0;
    m_rd2    = '0;
    m_rvalid = 1'b0;
    m_busy   = NREGS;
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    assert_reset();
    #2;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rvalid !== 1'b0 || bus.rd1 !== '0 || bus.rd2 !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rvalid=%b rd1=%h rd2=%h, need 1 0 0 0",
               bus.busy, bus.rvalid, bus.rd1, bus.rd2);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int c = 0; c < NREGS; c++) begin
      n_tests++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_sweep_busy cycle %0d: busy=%b need 1", c, bus.busy);
      end
      tick();
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sweep_end: busy=%b need 0", bus.busy);
    end
    for (int i = 0; i < NREGS; i++) begin
      bus.re = 1'b1; bus.ra1 = AW'(i); bus.ra2 = AW'(NREGS - 1 - i);
      tick();
      n_tests++;
      if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_readback reg %0d: rd1=%h rd2=%h rvalid=%b need 0 0 1",
                 i, bus.rd1, bus.rd2, bus.rvalid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
    tick();
    idle_inputs();
    bus.re = 1'b1; bus.ra1 = 5'd5; bus.ra2 = 5'd0;
    tick();
    n_tests++;
    if (bus.rd1 !== 32'hDEADBEEF || bus.rd2 !== 32'h0 || bus.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_read: rd1=%h rd2=%h rvalid=%b need deadbeef 0 1",
               bus.rd1, bus.rd2, bus.rvalid);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (bus.rvalid !== 1'b0 || bus.rd1 !== 32'hDEADBEEF || bus.rd2 !== 32'h0) begin
      n_fail++;
      $display("FAIL read_hold: rd1=%h rd2=%h rvalid=%b need deadbeef 0 0",
               bus.rd1, bus.rd2, bus.rvalid);
    end
  endtask

  task automatic test_bypass();
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h12345678;
    bus.re = 1'b1; bus.ra1 = 5'd7; bus.ra2 = 5'd7;
    tick();
    n_tests++;
    if (bus.rd1 !== 32'h12345678 || bus.rd2 !== 32'h12345678 || bus.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass: rd1=%h rd2=%h rvalid=%b need 12345678 12345678 1",
               bus.rd1, bus.rd2, bus.rvalid);
    end
    idle_inputs();
    bus.re = 1'b1; bus.ra1 = 5'd7; bus.ra2 = 5'd5;
    tick();
    n_tests++;
    if (bus.rd1 !== 32'h12345678 || bus.rd2 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_persist: rd1=%h rd2=%h need 12345678 deadbeef", bus.rd1, bus.rd2);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    bus.re = 1'b1; bus.ra1 = 5'd0; bus.ra2 = 5'd7;
    tick();
    n_tests++;
    if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL zero_reg_write: rd1=%h rd2=%h need 0 12345678", bus.rd1, bus.rd2);
    end
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hCAFEF00D;
    bus.re = 1'b1; bus.ra1 = 5'd0; bus.ra2 = 5'd0;
    tick();
    n_tests++;
    if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0 || bus.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_reg_bypass: rd1=%h rd2=%h rvalid=%b need 0 0 1",
               bus.rd1, bus.rd2, bus.rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    for (int i = 1; i < NREGS; i++) begin
      bus.we = 1'b1; bus.wa = AW'(i); bus.wd = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
    bus.re = 1'b1; bus.ra1 = 5'd9; bus.ra2 = 5'd31;
    tick();
    idle_inputs();
    bus.clear = 1'b1;
    tick();
    for (int c = 0; c < NREGS; c++) begin
      bus.clear = (c == 5);
      bus.we = 1'b1; bus.wa = AW'($urandom_range(1, NREGS - 1)); bus.wd = $urandom;
      bus.re = 1'b1; bus.ra1 = AW'($urandom); bus.ra2 = AW'($urandom);
      n_tests++;
      if (bus.busy !== 1'b1 || bus.rvalid !== 1'b0 || bus.rd1 !== m_rd1 || bus.rd2 !== m_rd2) begin
        n_fail++;
        $display("FAIL clear_busy cycle %0d: busy=%b rvalid=%b rd1=%h rd2=%h need 1 0 %h %h",
                 c, bus.busy, bus.rvalid, bus.rd1, bus.rd2, m_rd1, m_rd2);
      end
      tick();
    end
    idle_inputs();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_end: busy=%b rvalid=%b need 0 0", bus.busy, bus.rvalid);
    end
    for (int i = 0; i < NREGS; i++) begin
      bus.re = 1'b1; bus.ra1 = AW'(i); bus.ra2 = AW'(i);
      tick();
      n_tests++;
      if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL clear_readback reg %0d: rd1=%h rd2=%h rvalid=%b need 0 0 1",
                 i, bus.rd1, bus.rd2, bus.rvalid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    bus.re = 1'b1; bus.ra1 = 5'd3; bus.ra2 = 5'd3;
    tick();
    idle_inputs();
    bus.clear = 1'b1;
    tick();
    idle_inputs();
    for (int c = 0; c < 10; c++) tick();
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rd1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL pre_abort: busy=%b rd1=%h need 1 a5a5a5a5", bus.busy, bus.rd1);
    end
    assert_reset();
    #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rvalid !== 1'b0 || bus.rd1 !== '0 || bus.rd2 !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b rvalid=%b rd1=%h rd2=%h need 1 0 0 0",
               bus.busy, bus.rvalid, bus.rd1, bus.rd2);
    end
    tick(); tick();
    resetn = 1'b1;
    for (int c = 0; c < NREGS; c++) begin
      bus.re = 1'b1; bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h11111111;
      n_tests++;
      if (bus.busy !== 1'b1 || bus.rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_resweep cycle %0d: busy=%b rvalid=%b need 1 0", c, bus.busy, bus.rvalid);
      end
      tick();
    end
    idle_inputs();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_resweep_end: busy=%b need 0", bus.busy);
    end
    bus.re = 1'b1; bus.ra1 = 5'd3; bus.ra2 = 5'd4;
    tick();
    n_tests++;
    if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_readback: rd1=%h rd2=%h rvalid=%b need 0 0 1", bus.rd1, bus.rd2, bus.rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.we    = $urandom_range(0, 1);
      bus.wa    = AW'($urandom);
      bus.wd    = $urandom;
      bus.re    = $urandom_range(0, 2) != 0;
      bus.ra1   = ($urandom_range(0, 3) == 0) ? bus.wa : AW'($urandom);
      bus.ra2   = ($urandom_range(0, 3) == 0) ? bus.ra1 : AW'($urandom);
      bus.clear = ($urandom_range(0, 59) == 0);
      tick();
      n_tests++;
      if (bus.rd1 !== m_rd1 || bus.rd2 !== m_rd2 || bus.rvalid !== m_rvalid ||
          bus.busy !== (m_busy > 0)) begin
        n_fail++;
        $display("FAIL random cycle %0d: rd1=%h rd2=%h rvalid=%b busy=%b need %h %h %b %b",
                 c, bus.rd1, bus.rd2, bus.rvalid, bus.busy, m_rd1, m_rd2, m_rvalid, (m_busy > 0));
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, register count; power of two, minimum 2.
REQ-003 SHALL provide parameter AW, default 5, address width; equals log2(NREGS).
REQ-004 SHALL provide parameter ZERO_REG, default 1, which hardwires register 0 to zero when 1.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 ra1  input  AW  read address, port 1.
REQ-008 ra2  input  AW  read address, port 2.
REQ-009 re  input  1  read request; samples ra1 and ra2.
REQ-010 wa  input  AW  write address.
REQ-011 wd  input  XLEN  write data.
REQ-012 we  input  1  write enable.
REQ-013 clear  input  1  request to zero the whole array.
REQ-014 rd1  output  XLEN  registered read data, port 1.
REQ-015 rd2  output  XLEN  registered read data, port 2.
REQ-016 rvalid  output  1  rd1/rd2 updated by an accepted read in the previous cycle.
REQ-017 busy  output  1  clear sweep in progress; requests ignored.

Function
REQ-018 SHALL implement a two-state FSM: SWEEP and IDLE.
REQ-019 In SWEEP: counter idx SHALL start at 0, write zero to register idx each cycle, then increment idx.
REQ-020 SWEEP SHALL write index NREGS-1 and move to IDLE on that same edge, so the sweep lasts exactly NREGS cycles.
REQ-021 busy SHALL be 1 exactly while the FSM is in SWEEP.
REQ-022 In IDLE, clear=1 SHALL enter SWEEP with idx=0 on the next edge; we and re in that same cycle are still honoured.
REQ-023 clear while in SWEEP SHALL be ignored; the sweep does not restart.
REQ-024 While busy=1, we and re SHALL be ignored; rd1, rd2 hold, and rvalid=0.
REQ-025 Write: in IDLE with we=1, the edge SHALL store wd into register wa.
REQ-026 If ZERO_REG=1 and wa=0, the write SHALL be discarded.
REQ-027 Read: in IDLE with re=1, the edge SHALL load rd1 with reg[ra1] and rd2 with reg[ra2]; latency is one cycle.
REQ-028 rvalid SHALL be 1 in the cycle after an accepted read and 0 otherwise.
REQ-029 Without an accepted read, rd1 and rd2 SHALL hold their values.
REQ-030 Bypass: a read and a write accepted on the same edge with raN==wa (and wa writable) SHALL return wd on port N (write-first).
REQ-031 If ZERO_REG=1, reads of address 0 SHALL return 0 regardless of bypass.
REQ-032 Both ports reading the same address SHALL return identical data.
REQ-033 Address widths SHALL be exact; there is no out-of-range case.
REQ-034 Data SHALL pass through unmodified (no sign or zero extension).

Reset
REQ-035 resetn=0 SHALL immediately set rd1=0, rd2=0, rvalid=0, state=SWEEP, idx=0, busy=1.
REQ-036 Array contents SHALL NOT be reset asynchronously; the post-reset sweep zeroes them.
REQ-037 resetn asserted mid-sweep or mid-operation SHALL abort all activity; after release, a full NREGS-cycle sweep SHALL run again.
REQ-038 The first rising edge after resetn release SHALL be sweep cycle 0.

Verification
REQ-039 Reset release, NREGS=32: busy=1 for 32 cycles, then 0; re on every register SHALL read 0 on both ports.
REQ-040 Write 0xDEADBEEF to reg 5, then re with ra1=5, ra2=0: next cycle rd1=0xDEADBEEF, rd2=0, rvalid=1.
REQ-041 Same-edge we (wa=7, wd=0x12345678) and re (ra1=7, ra2=7): rd1=rd2=0x12345678; a later read of reg 7 SHALL return the same value.
REQ-042 Write 0xFFFFFFFF to reg 0 with ZERO_REG=1, then read reg 0: rd1=0.
REQ-043 Fill regs 1..31, pulse clear, issue we/re during busy: all writes dropped, rvalid stays 0; after 32 cycles all regs read 0.
REQ-044 Assert resetn=0 at sweep cycle 10: outputs clear immediately; after release, busy SHALL stay high for a further full 32 cycles.
